mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, meaning cycles from request capture to mem_resp; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the backing array; power of two.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mem_read  input  1  read request; level, may stay high through and after the response cycle.
REQ-006 mem_write  input  1  write request; may be a single-cycle pulse.
REQ-007 mem_address  input  32  byte address.
REQ-008 mem_wdata  input  32  write data.
REQ-009 mem_byte_en  input  4  write byte lanes; bit i enables bits [8i+7:8i].
REQ-010 mem_rdata  output  32  read data, registered.
REQ-011 mem_resp  output  1  one-cycle completion strobe for reads and writes.

Function
REQ-012 The block SHALL implement a 4-state FSM: IDLE, BUSY, RESP, RELEASE.
REQ-013 IDLE: if mem_read or mem_write is high at a rising edge, capture op, mem_address, mem_wdata and mem_byte_en, load cnt=LATENCY-1, and go to BUSY; otherwise stay.
REQ-014 When mem_read and mem_write are both high in IDLE, the write SHALL win, and no read is performed.
REQ-015 BUSY: if cnt==0, go to RESP; else decrement cnt. Request inputs are ignored; deasserting them SHALL NOT cancel the captured transaction.
REQ-016 Timing: for a capture at edge E0, mem_resp SHALL be high for exactly the one cycle following edge E0+LATENCY.
REQ-017 Word index = captured mem_address[log2(DEPTH_WORDS)+1:2]; bits [1:0] ignored; upper bits ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-018 Captured write: committed to the array at the BUSY->RESP edge, enabled lanes only; disabled lanes unchanged; mem_rdata unchanged.
REQ-019 Captured read: mem_rdata loaded with the full array word at the BUSY->RESP edge.
REQ-020 mem_rdata SHALL hold its value until the next read completes, so the initiator can sample it one or more cycles after mem_resp.
REQ-021 RESP lasts one cycle, then goes to RELEASE.
REQ-022 RELEASE: stay while mem_read or mem_write is high; go to IDLE when both are low. A held mem_read SHALL NOT start a second transaction.
REQ-023 Back-to-back minimum: a new request can be captured no earlier than the edge after the one where RELEASE observes both requests low.
REQ-024 Array contents are not reset; simulation initial content is all zeros.

Reset
REQ-025 When rst_n is low, the FSM SHALL enter IDLE immediately (asynchronously), with mem_resp=0, mem_rdata=32'h0 and cnt=0.
REQ-026 Reset during BUSY SHALL discard the pending transaction; a pending write SHALL NOT modify the array.
REQ-027 The first capture after reset deassertion SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-028 LATENCY=2: pulse mem_write one cycle at E0 with addr 0x10, wdata 0xDEADBEEF, byte_en 4'hF -> mem_resp high only in the cycle after E2. Then hold mem_read at addr 0x10 until resp, plus one cycle -> resp once, mem_rdata=0xDEADBEEF, and it stays so after resp.
REQ-029 Byte lanes: word 0x20=0x11223344; write 0xAABBCCDD with byte_en 4'b0101 -> a read of 0x20 returns 0x11BB33DD.
REQ-030 Wrap/alignment with DEPTH_WORDS=1024: write 0xCAFEF00D to 0x1000 -> a read of 0x0003 returns 0xCAFEF00D.
REQ-031 Hold mem_read high for 10 cycles after resp -> exactly one mem_resp; FSM in RELEASE until mem_read drops, then IDLE.
REQ-032 mem_read and mem_write both high in IDLE, addr 0x40, wdata 0x5 -> the write commits; a later read of 0x40 returns 0x5; mem_rdata is unchanged by the first transaction.
REQ-033 Assert rst_n low mid-BUSY during a write to 0x80 -> mem_resp never pulses, mem_rdata=0, and a later read of 0x80 returns the old value.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port memory responder: captures one read or write request, answers it LATENCY cycles
// later with a one-cycle mem_resp, then waits for the initiator to drop its request.
module mem_responder #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_en,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StRelease} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            op_write_q, op_write_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            complete;

  // Backing array: not reset.
  logic [31:0]     mem [DEPTH_WORDS];

  // Address bits outside the word index are deliberately ignored (addresses wrap).
  logic            unused_addr;
  assign unused_addr = ^{mem_address[31:AW+2], mem_address[1:0]};

  // The BUSY->RESP edge is where the captured operation takes effect.
  assign complete = (state_q == StBusy) && (cnt_q == 4'd0);

  // Next-state logic, request capture and read-data load.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (mem_read || mem_write) begin
          state_d    = StBusy;
          cnt_d      = CntLoad;
          op_write_d = mem_write;  // write wins when both are requested
          idx_d      = mem_address[AW+1:2];
          wdata_d    = mem_wdata;
          be_d       = mem_byte_en;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StRelease;
      StRelease: begin
        // A held request must not retrigger; wait for both requests to drop.
        if (!mem_read && !mem_write) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (complete && !op_write_q) begin
      rdata_d = mem[idx_q];
    end
  end

  // State and captured-request registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array write on completion of a captured write, enabled byte lanes only.
  always_ff @(posedge clk) begin
    if (complete && op_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = (state_q == StResp);

endmodule
